// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for an iterative AES-128 key-expansion datapath; 11 round keys land in a local store.
// Accept -> LOAD -> NROUNDS x STEP_LAT cycles -> DONE; store read port has one cycle of latency.
module aes_key_sched_ctrl #(
  parameter int STEP_LAT = 2,
  parameter int NROUNDS  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         exp_load,
  output logic         exp_step,
  output logic [127:0] exp_key,
  output logic [31:0]  exp_rcon,
  input  logic [127:0] exp_key_out,
  output logic         keys_ready,
  output logic         busy,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_e;

  localparam logic [3:0] CNT_LAST   = 4'(STEP_LAT - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q;
  logic [3:0]     round_q;
  logic [7:0]     rcon_q;
  logic [127:0]   key_q;
  logic [127:0]   rk_data_q;
  logic [127:0]   store_q [0:NROUNDS];
  logic           accept;
  logic           round_done;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // abort wins over a key offered in the same cycle
  assign accept     = key_valid && key_ready && !abort;
  assign round_done = (state_q == EXPAND) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : EXPAND;
      end
      EXPAND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (round_done && (round_q == LAST_ROUND)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_ready  = 1'b0;
    exp_load   = 1'b0;
    exp_step   = 1'b0;
    busy       = 1'b0;
    keys_ready = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
      end
      LOAD: begin
        exp_load = 1'b1;
        busy     = 1'b1;
      end
      EXPAND: begin
        busy     = 1'b1;
        exp_step = (cnt_q == 4'd0);
      end
      DONE: begin
        key_ready  = 1'b1;
        keys_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // rcon is primed at accept so it is already stable while LOAD is presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            key_q  <= key_in;
            rcon_q <= 8'h01;
          end
        end
        LOAD: begin
          round_q <= 4'd1;
          cnt_q   <= 4'd0;
          rcon_q  <= 8'h01;
        end
        EXPAND: begin
          if (round_done) begin
            cnt_q  <= 4'd0;
            rcon_q <= xtime(rcon_q);
            if (round_q != LAST_ROUND) begin
              round_q <= round_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      store_q[0] <= key_q;
    end else if (round_done) begin
      store_q[round_q] <= exp_key_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data_q <= '0;
    end else if (rk_addr <= LAST_ROUND) begin
      rk_data_q <= store_q[rk_addr];
    end else begin
      rk_data_q <= '0;
    end
  end

  assign exp_key  = key_q;
  assign exp_rcon = {rcon_q, 24'h000000};
  assign rk_data  = rk_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: two instances (STEP_LAT 2 and 4) each driving a behavioural key-expansion datapath.
// Stimulus pushes expected events into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] KF       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KF_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KF_RK2   = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] KF_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2       = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct { int cyc; logic [7:0] rc; } step_t;
  typedef struct { logic [3:0] a; logic [127:0] d; } rd_t;

  logic clk = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ndone = 0;
  logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen at cycle %0d, required none", nm, cyc);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {k[23:0], k[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int SL = (g == 0) ? 2 : 4;

    logic         rst = 1'b0;
    logic         key_valid = 1'b0;
    logic         abort = 1'b0;
    logic         rd_vld = 1'b0;
    logic         rd_pend = 1'b0;
    logic         kr_prev = 1'b0;
    logic         key_ready, exp_load, exp_step, keys_ready, busy;
    logic [127:0] key_in = '0;
    logic [127:0] dp = '0;
    logic [127:0] exp_key, rk_data;
    logic [31:0]  exp_rcon;
    logic [3:0]   rk_addr = '0;
    int           acc_q[$];
    int           ld_q[$];
    int           kr_q[$];
    step_t        st_q[$];
    rd_t          rd_q[$];
    step_t        s_cur;
    rd_t          r_cur;

    aes_key_sched_ctrl #(.STEP_LAT(SL), .NROUNDS(10)) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
      .abort(abort),
      .exp_load(exp_load), .exp_step(exp_step), .exp_key(exp_key), .exp_rcon(exp_rcon),
      .exp_key_out(dp),
      .keys_ready(keys_ready), .busy(busy),
      .rk_addr(rk_addr), .rk_data(rk_data)
    );

    always @(posedge clk) begin
      if (exp_load) dp <= exp_key;
      else if (exp_step) dp <= kexp(dp, exp_rcon[31:24]);
      rd_pend <= rd_vld;
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (exp_load && exp_step) unexp("load_with_step");
        if (exp_load) begin
          if (ld_q.size() == 0) unexp("exp_load");
          else chk("load_cycle", 128'(cyc), 128'(ld_q.pop_front()));
        end
        if (exp_step) begin
          if (st_q.size() == 0) unexp("exp_step");
          else begin
            s_cur = st_q.pop_front();
            chk("step_cycle", 128'(cyc), 128'(s_cur.cyc));
            chk("step_rcon", 128'(exp_rcon), 128'({s_cur.rc, 24'h000000}));
          end
        end
        if (keys_ready && !kr_prev) begin
          if (kr_q.size() == 0) unexp("keys_ready_rise");
          else chk("keys_ready_cycle", 128'(cyc), 128'(kr_q.pop_front()));
        end
        if (key_valid && key_ready && !abort) begin
          if (acc_q.size() == 0) unexp("key_accept");
          else chk("accept_cycle", 128'(cyc), 128'(acc_q.pop_front()));
        end
        if (rd_pend) begin
          if (rd_q.size() == 0) unexp("rk_read");
          else begin
            r_cur = rd_q.pop_front();
            chk($sformatf("rk_data[%0d]", r_cur.a), rk_data, r_cur.d);
          end
        end
      end
      kr_prev = keys_ready;
    end

    task automatic step_to(input int c);
      while (cyc < c) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic push_exp(input int a, input int nst);
      step_t s;
      acc_q.push_back(a);
      ld_q.push_back(a + 1);
      for (int k = 0; k < nst; k++) begin
        s.cyc = a + 2 + k * SL;
        s.rc  = rc_tab[k];
        st_q.push_back(s);
      end
      if (nst == 10) kr_q.push_back(a + 2 + 10 * SL);
    endtask

    task automatic start_key(input logic [127:0] k, input int nst, output int a);
      @(posedge clk);
      #1;
      a = cyc;
      key_in = k;
      key_valid = 1'b1;
      push_exp(a, nst);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] ad, input logic [127:0] d);
      rd_t r;
      r.a = ad;
      r.d = d;
      @(posedge clk);
      #1;
      rk_addr = ad;
      rd_vld = 1'b1;
      rd_q.push_back(r);
      @(posedge clk);
      #1;
      rd_vld = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
      chk({tag, "_key_ready"}, 128'(key_ready), 128'd1);
      chk({tag, "_exp_load"}, 128'(exp_load), 128'd0);
      chk({tag, "_exp_step"}, 128'(exp_step), 128'd0);
      chk({tag, "_busy"}, 128'(busy), 128'd0);
      chk({tag, "_keys_ready"}, 128'(keys_ready), 128'd0);
      chk({tag, "_exp_rcon"}, 128'(exp_rcon), 128'd0);
      chk({tag, "_exp_key"}, exp_key, 128'd0);
      chk({tag, "_rk_data"}, rk_data, 128'd0);
    endtask

    task automatic chk_left();
      chk("left_accepts", 128'(acc_q.size()), 128'd0);
      chk("left_loads", 128'(ld_q.size()), 128'd0);
      chk("left_steps", 128'(st_q.size()), 128'd0);
      chk("left_keys_ready", 128'(kr_q.size()), 128'd0);
      chk("left_reads", 128'(rd_q.size()), 128'd0);
    endtask

    if (g == 0) begin : t
      initial begin
        int a;
        #1 rst = 1'b1;
        #1 chk_reset("por");
        step_to(3);
        rst = 1'b0;

        // FIPS-197 expansion
        start_key(KF, 10, a);
        step_to(a + 5);
        chk("busy_mid", 128'(busy), 128'd1);
        chk("key_ready_mid", 128'(key_ready), 128'd0);
        step_to(a + 23);
        chk("busy_done", 128'(busy), 128'd0);
        chk("key_ready_done", 128'(key_ready), 128'd1);
        rd(4'd0, KF);
        rd(4'd1, KF_RK1);
        rd(4'd2, KF_RK2);
        rd(4'd10, KF_RK10);
        rd(4'd11, 128'h0);
        rd(4'd15, 128'h0);

        // second key held from A+3 must wait for DONE at A+22
        @(posedge clk);
        #1;
        a = cyc;
        key_in = KF;
        key_valid = 1'b1;
        push_exp(a, 10);
        push_exp(a + 22, 10);
        step_to(a + 1);
        key_valid = 1'b0;
        step_to(a + 3);
        key_in = K2;
        key_valid = 1'b1;
        step_to(a + 23);
        chk("bp_keys_ready_low", 128'(keys_ready), 128'd0);
        chk("bp_busy", 128'(busy), 128'd1);
        step_to(a + 26);
        key_valid = 1'b0;
        step_to(a + 45);
        rd(4'd0, K2);
        rd(4'd1, K2_RK1);
        rd(4'd10, K2_RK10);

        // abort during expansion
        @(posedge clk);
        #1;
        a = cyc;
        key_in = KF;
        key_valid = 1'b1;
        push_exp(a, 4);
        step_to(a + 1);
        key_valid = 1'b0;
        step_to(a + 9);
        abort = 1'b1;
        step_to(a + 10);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_keys_ready", 128'(keys_ready), 128'd0);
        chk("abort_key_ready", 128'(key_ready), 128'd1);
        chk("abort_exp_step", 128'(exp_step), 128'd0);
        step_to(a + 40);

        // asynchronous reset mid-expansion, then a clean run
        @(posedge clk);
        #1;
        a = cyc;
        key_in = KF;
        key_valid = 1'b1;
        push_exp(a, 7);
        step_to(a + 1);
        key_valid = 1'b0;
        step_to(a + 15);
        #1 rst = 1'b1;
        #1 chk_reset("mid");
        #1 rst = 1'b0;
        start_key(KF, 10, a);
        step_to(a + 23);
        rd(4'd0, KF);
        rd(4'd10, KF_RK10);

        // abort beats a key offered in DONE
        @(posedge clk);
        #1;
        key_in = K2;
        key_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        abort = 1'b0;
        chk("abort_done_keys_ready", 128'(keys_ready), 128'd0);
        chk("abort_done_busy", 128'(busy), 128'd0);
        chk("abort_done_key_ready", 128'(key_ready), 128'd1);
        @(posedge clk);
        #1;
        chk("abort_done_no_load", 128'(exp_load), 128'd0);
        step_to(cyc + 4);
        chk_left();
        ndone++;
      end
    end else begin : t
      initial begin
        int a;
        #1 rst = 1'b1;
        #1 chk_reset("por_sl4");
        step_to(3);
        rst = 1'b0;
        start_key(KF, 10, a);
        step_to(a + 43);
        chk("sl4_busy_done", 128'(busy), 128'd0);
        rd(4'd0, KF);
        rd(4'd1, KF_RK1);
        rd(4'd2, KF_RK2);
        rd(4'd10, KF_RK10);
        step_to(cyc + 4);
        chk_left();
        ndone++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 5000 && ndone < 2; i++) @(posedge clk);
    if (ndone < 2) begin
      checks++;
      errors++;
      $display("FAIL timeout: sequences_done=%0d required 2", ndone);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
